// File: rtl/ps2_host_tx_param_if.sv
// Command-side handshake between the mouse command logic and the PS/2 transmitter.
// master = command logic, slave = transmitter; carries request, byte, ready and result pulses.
interface ps2_host_tx_param_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       READY;
    logic       BYTE_SENT;
    logic       ERROR_NOACK;
    logic       ERROR_TIMEOUT;

    modport master (
        output SEND_BYTE, BYTE_TO_SEND,
        input  READY, BYTE_SENT, ERROR_NOACK, ERROR_TIMEOUT
    );

    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND,
        output READY, BYTE_SENT, ERROR_NOACK, ERROR_TIMEOUT
    );
endinterface

// File: rtl/ps2_host_tx_param.sv
// PS/2 host-to-device byte transmitter: inhibit, request, 11-bit frame, ack, watchdog.
// Ports: CLK/RESET_N, PS/2 clock+data pad in/enables, cmd = command handshake (slave).
module ps2_host_tx_param #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_US  = 15000,
    parameter int FILTER_LEN  = 4,
    parameter bit PARITY_ODD  = 1'b1
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLK_MOUSE_IN,
    output logic CLK_MOUSE_OUT_EN,
    input  logic DATA_MOUSE_IN,
    output logic DATA_MOUSE_OUT,
    output logic DATA_MOUSE_OUT_EN,
    ps2_host_tx_param_if.slave cmd
);
    localparam int CYC_US      = CLK_FREQ_HZ / 1000000;
    localparam int INHIBIT_CYC = CYC_US * INHIBIT_US;
    localparam int TIMEOUT_CYC = CYC_US * TIMEOUT_US;
    localparam int INH_W       = $clog2(INHIBIT_CYC) + 1;
    localparam int WDG_W       = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYC);
    localparam logic [WDG_W-1:0] WDG_MAX  = WDG_W'(TIMEOUT_CYC);
    localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_START, S_DATA,
        S_PARITY, S_STOP, S_RELEASE, S_ACK, S_LINE_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic             filt_q, filt_d;
    logic [3:0]       flt_cnt_q, flt_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [WDG_W-1:0] wdg_q, wdg_d;
    logic             nack_q, nack_d;
    logic             clk_en_q, clk_en_d;
    logic             dout_q, dout_d;
    logic             den_q, den_d;
    logic             ready_q, ready_d;
    logic             sent_q, sent_d;
    logic             noack_q, noack_d;
    logic             tmo_q, tmo_d;

    logic             fall;
    logic             par;
    logic             done;
    logic             wdg_run;
    logic [WDG_W-1:0] wdg_nxt;

    always_comb begin
        clk_s1_d = CLK_MOUSE_IN;
        clk_s2_d = clk_s1_q;
        dat_s1_d = DATA_MOUSE_IN;
        dat_s2_d = dat_s1_q;

        // Any sample equal to the filtered value restarts the run count.
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q >= FLT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
        fall = filt_q & ~filt_d;

        par = PARITY_ODD ? ~^byte_q : ^byte_q;

        state_d  = state_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        inh_d    = inh_q;
        wdg_d    = wdg_q;
        nack_d   = nack_q;
        clk_en_d = clk_en_q;
        dout_d   = dout_q;
        den_d    = den_q;
        ready_d  = ready_q;
        sent_d   = 1'b0;
        noack_d  = 1'b0;
        tmo_d    = 1'b0;

        done    = (state_q == S_LINE_IDLE) && dat_s2_q && filt_q;
        wdg_run = state_q inside {[S_START:S_LINE_IDLE]};
        wdg_nxt = (wdg_q >= WDG_MAX) ? WDG_MAX : wdg_q + WDG_W'(1);

        unique case (state_q)
            S_IDLE: begin
                ready_d  = 1'b1;
                clk_en_d = 1'b0;
                den_d    = 1'b0;
                dout_d   = 1'b0;
                if (ready_q && cmd.SEND_BYTE) begin
                    byte_d   = cmd.BYTE_TO_SEND;
                    ready_d  = 1'b0;
                    clk_en_d = 1'b1;
                    inh_d    = INH_W'(1);
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q >= INH_MAX) begin
                    clk_en_d = 1'b0;
                    den_d    = 1'b1;
                    dout_d   = 1'b0;
                    // The REQ cycle itself is the first watchdog count.
                    wdg_d    = WDG_W'(1);
                    state_d  = S_REQ;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            S_REQ: begin
                state_d = S_START;
            end
            S_START: begin
                if (fall) begin
                    dout_d  = byte_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fall) begin
                    if (bit_q == 3'd7) begin
                        dout_d  = par;
                        state_d = S_PARITY;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        dout_d = byte_q[bit_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    dout_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    den_d   = 1'b0;
                    dout_d  = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                if (fall) begin
                    nack_d  = dat_s2_q;
                    state_d = S_LINE_IDLE;
                end
            end
            S_LINE_IDLE: begin
                if (done) begin
                    sent_d  = ~nack_q;
                    noack_d = nack_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wdg_run) begin
            wdg_d = wdg_nxt;
            // Completion on the expiry cycle takes priority.
            if (wdg_nxt >= WDG_MAX && !done) begin
                tmo_d    = 1'b1;
                clk_en_d = 1'b0;
                den_d    = 1'b0;
                dout_d   = 1'b0;
                state_d  = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
            byte_q    <= '0;
            bit_q     <= '0;
            inh_q     <= '0;
            wdg_q     <= '0;
            nack_q    <= 1'b0;
            clk_en_q  <= 1'b0;
            dout_q    <= 1'b0;
            den_q     <= 1'b0;
            ready_q   <= 1'b1;
            sent_q    <= 1'b0;
            noack_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_s1_q  <= clk_s1_d;
            clk_s2_q  <= clk_s2_d;
            dat_s1_q  <= dat_s1_d;
            dat_s2_q  <= dat_s2_d;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            inh_q     <= inh_d;
            wdg_q     <= wdg_d;
            nack_q    <= nack_d;
            clk_en_q  <= clk_en_d;
            dout_q    <= dout_d;
            den_q     <= den_d;
            ready_q   <= ready_d;
            sent_q    <= sent_d;
            noack_q   <= noack_d;
            tmo_q     <= tmo_d;
        end
    end

    assign CLK_MOUSE_OUT_EN  = clk_en_q;
    assign DATA_MOUSE_OUT    = dout_q;
    assign DATA_MOUSE_OUT_EN = den_q;
    assign cmd.READY         = ready_q;
    assign cmd.BYTE_SENT     = sent_q;
    assign cmd.ERROR_NOACK   = noack_q;
    assign cmd.ERROR_TIMEOUT = tmo_q;
endmodule

// File: tb/tb_ps2_host_tx_param.sv
// Bench for ps2_host_tx_param: odd and even parity instances on a shared open-drain bus,
// driven by a PS/2 device model and checked against a frame/pulse reference model.
module tb_ps2_host_tx_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clk_en_a, dout_a, den_a;
    logic clk_en_b, dout_b, den_b;
    logic dev_clk_low, dev_data_low, glitch;
    logic ps2_clk, ps2_data;
    logic sel;

    ps2_host_tx_param_if if_a ();
    ps2_host_tx_param_if if_b ();

    assign ps2_clk  = ~(dev_clk_low | glitch | clk_en_a | clk_en_b);
    assign ps2_data = ~(dev_data_low | (den_a & ~dout_a) | (den_b & ~dout_b));

    ps2_host_tx_param #(
        .CLK_FREQ_HZ(50000000), .INHIBIT_US(2), .TIMEOUT_US(20),
        .FILTER_LEN(4), .PARITY_ODD(1'b1)
    ) dut_a (
        .CLK(clk), .RESET_N(rst_n),
        .CLK_MOUSE_IN(ps2_clk), .CLK_MOUSE_OUT_EN(clk_en_a),
        .DATA_MOUSE_IN(ps2_data), .DATA_MOUSE_OUT(dout_a),
        .DATA_MOUSE_OUT_EN(den_a), .cmd(if_a)
    );

    ps2_host_tx_param #(
        .CLK_FREQ_HZ(50000000), .INHIBIT_US(2), .TIMEOUT_US(20),
        .FILTER_LEN(4), .PARITY_ODD(1'b0)
    ) dut_b (
        .CLK(clk), .RESET_N(rst_n),
        .CLK_MOUSE_IN(ps2_clk), .CLK_MOUSE_OUT_EN(clk_en_b),
        .DATA_MOUSE_IN(ps2_data), .DATA_MOUSE_OUT(dout_b),
        .DATA_MOUSE_OUT_EN(den_b), .cmd(if_b)
    );

    logic s_clk_en, s_den, s_ready, s_sent, s_nack, s_tmo;
    assign s_clk_en = sel ? clk_en_b : clk_en_a;
    assign s_den    = sel ? den_b : den_a;
    assign s_ready  = sel ? if_b.READY : if_a.READY;
    assign s_sent   = sel ? if_b.BYTE_SENT : if_a.BYTE_SENT;
    assign s_nack   = sel ? if_b.ERROR_NOACK : if_a.ERROR_NOACK;
    assign s_tmo    = sel ? if_b.ERROR_TIMEOUT : if_a.ERROR_TIMEOUT;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_sent = 0, n_nack = 0, n_tmo = 0;
    int run = 0, last_run = 0;
    int req_cyc = 0, tmo_cyc = 0;
    logic tmo_den = 1'b0;
    logic den_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_sent) n_sent++;
        if (s_nack) n_nack++;
        if (s_tmo) begin
            n_tmo++;
            tmo_cyc = cyc;
            tmo_den = s_den;
        end
        if (s_den && !den_prev) req_cyc = cyc;
        den_prev = s_den;
        if (s_clk_en) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected 11-bit frame, bit 0 first on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] b,
                                             input bit odd);
        int ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send(input bit s, input logic [7:0] b);
        sel = s;
        tick();
        if (s) begin
            if_b.SEND_BYTE = 1'b1;
            if_b.BYTE_TO_SEND = b;
        end else begin
            if_a.SEND_BYTE = 1'b1;
            if_a.BYTE_TO_SEND = b;
        end
        tick();
        if_a.SEND_BYTE = 1'b0;
        if_b.SEND_BYTE = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int t = 0;
        while (!(s_den && !s_clk_en) && t < 5000) begin
            tick();
            t++;
        end
        ok = (t < 5000);
    endtask

    task automatic device(input bit ack, input int ngl,
                          output logic [10:0] fr, output bit ok);
        fr = '0;
        wait_req(ok);
        if (!ok) return;
        repeat (20) tick();
        for (int k = 0; k < 11; k++) begin
            fr[k] = ps2_data;
            dev_clk_low = 1'b1;
            repeat (20) tick();
            dev_clk_low = 1'b0;
            if (k >= 1 && k <= ngl) begin
                repeat (10) tick();
                glitch = 1'b1;
                repeat (2) tick();
                glitch = 1'b0;
                repeat (8) tick();
            end else begin
                repeat (20) tick();
            end
        end
        if (ack) dev_data_low = 1'b1;
        dev_clk_low = 1'b1;
        repeat (20) tick();
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic run_txn(input bit s, input logic [7:0] b, input bit ack,
                           input int ngl, input string tag,
                           output logic [10:0] fr);
        int s0, n0, t0, w;
        bit ok;
        s0 = n_sent;
        n0 = n_nack;
        t0 = n_tmo;
        send(s, b);
        device(ack, ngl, fr, ok);
        chk({tag, "_req"}, 32'(ok), 1);
        w = 0;
        while (!s_ready && w < 200) begin
            tick();
            w++;
        end
        chk({tag, "_ready"}, 32'(s_ready), 1);
        chk({tag, "_frame"}, 32'(fr), 32'(frame_of(b, !s)));
        chk({tag, "_sent"}, n_sent - s0, ack ? 1 : 0);
        chk({tag, "_noack"}, n_nack - n0, ack ? 0 : 1);
        chk({tag, "_tmo"}, n_tmo - t0, 0);
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0] rb;
        bit rs, rack, ok;
        int s0, n0, t0, w;

        sel = 1'b0;
        rst_n = 1'b0;
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        glitch = 1'b0;
        if_a.SEND_BYTE = 1'b0;
        if_a.BYTE_TO_SEND = '0;
        if_b.SEND_BYTE = 1'b0;
        if_b.BYTE_TO_SEND = '0;
        repeat (4) tick();

        chk("rst_ready_a", 32'(if_a.READY), 1);
        chk("rst_ready_b", 32'(if_b.READY), 1);
        chk("rst_clk_en", 32'({clk_en_a, clk_en_b}), 0);
        chk("rst_den", 32'({den_a, den_b}), 0);
        chk("rst_dout", 32'({dout_a, dout_b}), 0);
        chk("rst_pulses", 32'({if_a.BYTE_SENT, if_a.ERROR_NOACK,
                               if_a.ERROR_TIMEOUT}), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        run_txn(1'b0, 8'hF4, 1'b1, 0, "t1", fr);
        chk("t1_inhibit_len", last_run, 100);
        chk("t1_frame_lit", 32'(fr), 32'h5E8);

        run_txn(1'b0, 8'hFF, 1'b1, 0, "t2_odd", fr);
        chk("t2_odd_par", 32'(fr[9]), 1);
        run_txn(1'b1, 8'hFF, 1'b1, 0, "t2_even", fr);
        chk("t2_even_par", 32'(fr[9]), 0);

        run_txn(1'b0, 8'h3C, 1'b0, 0, "t3", fr);

        run_txn(1'b0, 8'h96, 1'b1, 8, "t5", fr);

        for (int i = 0; i < 6; i++) begin
            rs = 1'(($urandom) & 1);
            rb = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            run_txn(rs, rb, rack, int'($urandom_range(0, 8)), "rnd", fr);
        end

        // Device never clocks: watchdog must fire.
        s0 = n_sent;
        t0 = n_tmo;
        send(1'b0, 8'h12);
        w = 0;
        while (n_tmo == t0 && w < 3000) begin
            tick();
            w++;
        end
        chk("t4_tmo_seen", n_tmo - t0, 1);
        chk("t4_tmo_delay", tmo_cyc - req_cyc, 1000);
        chk("t4_tmo_den", 32'(tmo_den), 0);
        tick();
        chk("t4_ready", 32'(s_ready), 1);
        chk("t4_no_sent", n_sent - s0, 0);

        // Busy re-request, then reset mid-DATA.
        send(1'b0, 8'h5C);
        wait_req(ok);
        chk("t6_req", 32'(ok), 1);
        repeat (20) tick();
        for (int k = 0; k < 3; k++) begin
            dev_clk_low = 1'b1;
            repeat (20) tick();
            dev_clk_low = 1'b0;
            repeat (20) tick();
        end
        chk("t6_busy_ready", 32'(s_ready), 0);
        send(1'b0, 8'h33);
        repeat (5) tick();
        chk("t6_ignored", 32'(s_clk_en), 0);
        chk("t6_still_den", 32'(s_den), 1);
        s0 = n_sent;
        n0 = n_nack;
        t0 = n_tmo;
        rst_n = 1'b0;
        tick();
        chk("t6_rst_lines", 32'({clk_en_a, den_a}), 0);
        chk("t6_rst_ready", 32'(if_a.READY), 1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("t6_no_pulse", (n_sent - s0) + (n_nack - n0) + (n_tmo - t0), 0);
        chk("t6_idle", 32'({s_ready, s_clk_en, s_den}), 3'b100);
        run_txn(1'b0, 8'hAA, 1'b1, 0, "t6_after", fr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
